cache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate cache controller sitting directly upstream of the cache data array (256 lines x 4 x 32-bit words, index = addr[11:4], word offset = addr[3:2], 1-cycle registered read).
- Holds the tag, valid and dirty state, and runs the CPU request/response handshake.
- On a miss it evicts a dirty victim line to memory, refills the line from memory, then replays the request.
- Drives the data array port exclusively.

---
 rtl/cache_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_cache_controller.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache controller: tag/valid/dirty state, CPU handshake,
// dirty-victim write-back and line refill. Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module cache_controller #(
  parameter int ADDR_W = 32,
  parameter int LINES  = 256,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [31:0]       cpu_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic [ADDR_W-1:0] dar_address,
  output logic              dar_write_enable,
  output logic [31:0]       dar_write_data,
  input  logic [31:0]       dar_read_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - 12;
  localparam logic [1:0] LAST_BEAT = 2'(WORDS - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_WB_RD       = 3'd2;
  localparam logic [2:0] S_WB_WR       = 3'd3;
  localparam logic [2:0] S_REFILL_REQ  = 3'd4;
  localparam logic [2:0] S_REFILL_WAIT = 3'd5;
  localparam logic [2:0] S_REPLAY      = 3'd6;
  localparam logic [2:0] S_RESP        = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              replay_q, replay_d;
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q [LINES];

  logic [7:0]        idx;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] victim_addr;
  logic              hit;
  logic              set_dirty;
  logic              fill_done;

  assign idx         = addr_q[11:4];
  assign req_tag     = addr_q[ADDR_W-1:12];
  assign victim_addr = {tag_q[idx], idx, k_q, 2'b00};
  assign hit         = valid_q[idx] && (tag_q[idx] == req_tag);

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    replay_d         = replay_q;
    set_dirty        = 1'b0;
    fill_done        = 1'b0;
    cpu_req_ready    = 1'b0;
    cpu_resp_valid   = 1'b0;
    cpu_resp_rdata   = '0;
    mem_req_valid    = 1'b0;
    mem_req_we       = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    dar_address      = '0;
    dar_write_enable = 1'b0;
    dar_write_data   = '0;
    case (state_q)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          dar_address = cpu_req_addr;
          we_d        = cpu_req_we;
          addr_d      = cpu_req_addr;
          wdata_d     = cpu_req_wdata;
          replay_d    = 1'b0;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rdata_d = we_q ? '0 : dar_read_data;
          if (we_q) begin
            dar_write_enable = 1'b1;
            dar_address      = addr_q;
            dar_write_data   = wdata_q;
            set_dirty        = 1'b1;
          end
          state_d = S_RESP;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          k_d     = 2'd0;
          state_d = S_WB_RD;
        end else begin
          state_d = S_REFILL_REQ;
        end
      end
      S_WB_RD: begin
        dar_address = victim_addr;
        state_d     = S_WB_WR;
      end
      // Address stays on the array so the registered read data is stable while stalled.
      S_WB_WR: begin
        dar_address   = victim_addr;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = victim_addr;
        mem_req_wdata = dar_read_data;
        if (mem_req_ready) begin
          if (k_q == LAST_BEAT) begin
            state_d = S_REFILL_REQ;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_WB_RD;
          end
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, idx, 4'b0000};
        if (mem_req_ready) begin
          k_d     = 2'd0;
          state_d = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          dar_write_enable = 1'b1;
          dar_address      = {req_tag, idx, k_q, 2'b00};
          dar_write_data   = mem_resp_rdata;
          if (k_q == LAST_BEAT) begin
            fill_done = 1'b1;
            state_d   = S_REPLAY;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      S_REPLAY: begin
        dar_address = addr_q;
        replay_d    = 1'b1;
        state_d     = S_LOOKUP;
      end
      S_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = rdata_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      replay_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      replay_q <= replay_d;
      if (set_dirty) dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tags need no reset: a line's tag is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[idx] <= req_tag;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Only the first lookup of a request counts; the post-refill replay would double count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == S_LOOKUP && !replay_q) begin
      if (hit) begin
        if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
      end else begin
        if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: table of CPU requests checked against a response scoreboard,
// plus hand-written write-back stall and mid-refill reset sequences.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [31:0] dar_address;
  logic        dar_write_enable;
  logic [31:0] dar_write_data;
  logic [31:0] dar_read_data;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_controller dut (
    .clk(clk),
    .rst(rst),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .dar_address(dar_address),
    .dar_write_enable(dar_write_enable),
    .dar_write_data(dar_write_data),
    .dar_read_data(dar_read_data)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct packed {
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      expData;
    logic             expHit;
    logic [3:0]       expWb;
    logic [31:0]      wbBase;
    logic [3:0][31:0] wbData;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } memTxn_t;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  int respCount = 0;
  int respBase = 0;
  int lastRespCycle = 0;
  int darWrites = 0;
  logic [31:0] expQ [$];
  memTxn_t     memLog [$];
  logic [31:0] respQ [$];
  logic [31:0] wbMem [logic [31:0]];
  logic [31:0] darMem [256][4];

  int          respLimit = -1;
  int          beatsDelivered = 0;
  bit          gapMode = 0;
  bit          stallArm = 0;
  int          stallLeft = 0;
  int          stallSeen = 0;
  int          stallBad = 0;
  logic [31:0] stallAddr = 0;
  logic [31:0] stallData = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt = cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Backing memory: written-back words, otherwise a pattern giving 0xA0..0xA3 for line 0x1230.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] lineNo;
    if (wbMem.exists(a)) return wbMem[a];
    lineNo = (a >> 4) ^ 32'h123;
    return (lineNo << 8) | (32'hA0 + {30'd0, a[3:2]});
  endfunction

  // Data array: 1-cycle registered read, write on strobe.
  always @(posedge clk) begin
    if (dar_write_enable) darMem[dar_address[11:4]][dar_address[3:2]] <= dar_write_data;
    dar_read_data <= darMem[dar_address[11:4]][dar_address[3:2]];
  end

  // Memory responder, acting at the falling edge so handshakes land on the next rising edge.
  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (respQ.size() > 0 && (respLimit < 0 || beatsDelivered < respLimit) &&
          !(gapMode && $urandom_range(0, 1) == 0)) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = respQ.pop_front();
        beatsDelivered++;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
      end
      if (stallArm && mem_req_valid && mem_req_we) begin
        stallArm  = 0;
        stallLeft = 5;
        stallAddr = mem_req_addr;
        stallData = mem_req_wdata;
      end
      if (stallLeft > 0) begin
        mem_req_ready = 1'b0;
        stallLeft--;
        stallSeen++;
        if (!mem_req_valid || mem_req_addr !== stallAddr || mem_req_wdata !== stallData) stallBad++;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        memLog.push_back('{mem_req_we, mem_req_addr, mem_req_wdata});
        if (mem_req_we) begin
          wbMem[mem_req_addr] = mem_req_wdata;
        end else begin
          for (int w = 0; w < 4; w++) respQ.push_back(memWord(mem_req_addr + 32'(4 * w)));
        end
      end
    end
  end

  // Response scoreboard: every response pulse pops the oldest expected value.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (dar_write_enable) darWrites++;
    if (cpu_resp_valid) begin
      respCount++;
      lastRespCycle = cycleCnt;
      checkOutput("resp_pending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        exp = expQ.pop_front();
        checkOutput("resp_data", cpu_resp_rdata, exp);
      end
    end
  end

  task automatic applyStimulus(input vec_t v, output int acceptCycle);
    int n;
    @(negedge clk);
    memLog.delete();
    darWrites = 0;
    respBase = respCount;
    cpu_req_valid = 1'b1;
    cpu_req_we    = v.we;
    cpu_req_addr  = v.addr;
    cpu_req_wdata = v.wdata;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready", 32'(cpu_req_ready), 32'd1);
    expQ.push_back(v.expData);
    acceptCycle = cycleCnt;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
  endtask

  task automatic runVector(input vec_t v);
    int acc;
    int n;
    int nWb;
    int nRd;
    logic [31:0] rdAddr;
    applyStimulus(v, acc);
    n = 0;
    while (respCount == respBase && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_seen", 32'(respCount - respBase), 32'd1);
    if (v.expHit) checkOutput("hit_latency", 32'(lastRespCycle - acc), 32'd2);
    else checkOutput("miss_latency_gt2", 32'((lastRespCycle - acc) > 2), 32'd1);
    nWb = 0;
    nRd = 0;
    rdAddr = '0;
    foreach (memLog[j]) begin
      if (memLog[j].we) begin
        if (nWb < 4) begin
          checkOutput("wb_addr", memLog[j].addr, v.wbBase + 32'(4 * nWb));
          checkOutput("wb_data", memLog[j].data, v.wbData[nWb[1:0]]);
        end
        nWb++;
      end else begin
        nRd++;
        rdAddr = memLog[j].addr;
      end
    end
    checkOutput("wb_beats", 32'(nWb), 32'(v.expWb));
    checkOutput("line_reads", 32'(nRd), v.expHit ? 32'd0 : 32'd1);
    if (!v.expHit) checkOutput("refill_addr", rdAddr, {v.addr[31:4], 4'h0});
    checkOutput("dar_writes", 32'(darWrites), 32'(v.we) + (v.expHit ? 32'd0 : 32'd4));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(cpu_req_ready), 32'd1);
    checkOutput({tag, "_strobes"},
                {28'd0, cpu_resp_valid, mem_req_valid, mem_req_we, dar_write_enable}, 32'd0);
    checkOutput({tag, "_resp_rdata"}, cpu_resp_rdata, 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_req_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_req_wdata, 32'd0);
    checkOutput({tag, "_dar_addr"}, dar_address, 32'd0);
    checkOutput({tag, "_dar_wdata"}, dar_write_data, 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    int n;
    int base;
    vec_t v;
    vecs[0] = '{1'b0, 32'h1230, 32'h0, 32'h0000_00A0, 1'b0, 4'd0, 32'h0, 128'h0};
    vecs[1] = '{1'b0, 32'h1234, 32'h0, 32'h0000_00A1, 1'b1, 4'd0, 32'h0, 128'h0};
    vecs[2] = '{1'b1, 32'h1238, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'd0, 32'h0, 128'h0};
    vecs[3] = '{1'b0, 32'h2238, 32'h0, 32'h0003_00A2, 1'b0, 4'd4, 32'h1230,
                {32'h0000_00A3, 32'hDEAD_BEEF, 32'h0000_00A1, 32'h0000_00A0}};
    vecs[4] = '{1'b0, 32'h1238, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0, 128'h0};
    vecs[5] = '{1'b1, 32'h5670, 32'h1234_5678, 32'h0, 1'b0, 4'd0, 32'h0, 128'h0};
    vecs[6] = '{1'b0, 32'h5670, 32'h0, 32'h1234_5678, 1'b1, 4'd0, 32'h0, 128'h0};
    vecs[7] = '{1'b0, 32'h5674, 32'h0, 32'h0004_44A1, 1'b1, 4'd0, 32'h0, 128'h0};

    for (int a = 0; a < 256; a++)
      for (int w = 0; w < 4; w++) darMem[a][w] = '0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkIdle("reset");

    gapMode = 1;
    for (int i = 0; i < 8; i++) runVector(vecs[i]);
    gapMode = 0;

    // Dirty victim 0x5670 evicted with the first write beat held off for 5 cycles.
    stallArm = 1;
    stallSeen = 0;
    stallBad = 0;
    v = '{1'b0, 32'h6670, 32'h0, 32'h0007_44A0, 1'b0, 4'd4, 32'h5670,
          {32'h0004_44A3, 32'h0004_44A2, 32'h0004_44A1, 32'h1234_5678}};
    runVector(v);
    checkOutput("stall_cycles", 32'(stallSeen), 32'd5);
    checkOutput("stall_stable", 32'(stallBad), 32'd0);

    // Reset while the refill has delivered only two beats.
    respLimit = 2;
    beatsDelivered = 0;
    v = '{1'b0, 32'h7770, 32'h0, 32'h0006_54A0, 1'b0, 4'd0, 32'h0, 128'h0};
    applyStimulus(v, n);
    n = 0;
    while (beatsDelivered < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("beats_before_reset", 32'(beatsDelivered), 32'd2);
    @(negedge clk);
    base = respCount;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    respQ.delete();
    respLimit = -1;
    checkIdle("midreset");
    checkOutput("no_resp_after_reset", 32'(respCount - base), 32'd0);

    runVector(v);
    runVector('{1'b0, 32'h7774, 32'h0, 32'h0006_54A1, 1'b1, 4'd0, 32'h0, 128'h0});
    runVector('{1'b0, 32'h7778, 32'h0, 32'h0006_54A2, 1'b1, 4'd0, 32'h0, 128'h0});
`ifdef CACHE_STATS_EN
    checkOutput("miss_count", miss_count, 32'd1);
    checkOutput("hit_count", hit_count, 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
